dbg_7seg_scan: RTL
==================

Name: dbg_7seg_scan

Overview:
Parametrised multiplexed 7-segment debug display driver. It is the next-generation replacement for the fixed 8-digit hex display on the board top level. It scans N digits, showing CPU debug nibbles such as PC, SREG and opcode number. Over the fixed scanner it adds:
- frame-coherent snapshotting of the displayed value
- per-digit decimal point and forced blanking
- optional leading-zero suppression
- PWM brightness
- anti-ghosting guard time
- configurable output polarity

Parameters:
DIGITS, 8, number of digits scanned (2..16)
SCAN_DIV, 3125, clk cycles each digit is selected (dwell); must be > GUARD
GUARD, 2, cycles at the start of each dwell with all digits off (anti-ghosting)
BRIGHT_W, 4, width of the brightness input
SEG_ACT_LOW, 1, 1 = segment lines are active-low
RAZR_ACT_LOW, 1, 1 = digit-select lines are active-low

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
din  in  4*DIGITS  hex nibbles; digit i = din[4i+3:4i]; digit 0 is rightmost / least significant
dp  in  DIGITS  decimal point per digit, 1 = lit
blank  in  DIGITS  force digit off, 1 = blank
bright  in  BRIGHT_W  brightness, 0 = dimmest, all-ones = full
lz_en  in  1  leading-zero suppression enable
freeze  in  1  1 = hold current snapshot (no recapture)
RAZR  out  DIGITS  digit selects, one-hot when active
SEG  out  8  SEG[0..6] = a..g, SEG[7] = dp
frame  out  1  one-cycle pulse at each frame start (the snapshot cycle)

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - state: cnt=0, idx=0, all snapshot registers, lz mask
  - outputs: RAZR all inactive (all 1s if RAZR_ACT_LOW), SEG all inactive, frame=0
- Reset mid-frame aborts the scan immediately; there is no completion of the current digit.
- Dwell counter cnt counts 0..SCAN_DIV-1. At the terminal count it returns to 0 and idx advances. idx wraps DIGITS-1 -> 0.
- Frame start is the cycle with idx==0 and cnt==0:
  - if freeze=0, din, dp and blank are captured into snapshot registers and the lz mask is computed from the captured din
  - if freeze=1, the snapshot is held
  - frame pulses on this cycle regardless of freeze
  - the first frame start is the first cycle after reset deasserts
- lz mask (only when lz_en=1):
  - digit k is suppressed if all snapshot nibbles k..DIGITS-1 are zero
  - digit 0 is never suppressed
  - lz_en is sampled combinationally each cycle; the mask itself updates only at capture
- on_len = ((bright+1) * (SCAN_DIV-GUARD)) >> BRIGHT_W. Width is sufficient for the product, with no truncation before the shift.
- Digit idx is lit when all of the following hold:
  - GUARD <= cnt < GUARD+on_len
  - snapshot blank[idx]=0
  - idx is not suppressed by lz
- When lit, RAZR selects only idx, and SEG = decode(snapshot nibble idx) with dp[idx] in bit 7. Otherwise RAZR and SEG are all inactive.
- Polarity: all-active-high values are computed first, then inverted per *_ACT_LOW.
- Decode, active-high gfedcba:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- RAZR, SEG and frame are registered: each reflects the cnt/idx state of the previous cycle (latency 1). RAZR is never multi-hot, including across a digit change, because GUARD>=1 is required (GUARD=0 is permitted only with a glitch-tolerant board).
- Simultaneous events:
  - freeze rising on the frame-start cycle: freeze wins, no capture
  - changes to bright take effect on the next cycle's compare; there is no frame alignment

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table
  - segment bit index constants (SEG_A..SEG_G, SEG_DP)
  - the function computing on_len width from SCAN_DIV and BRIGHT_W
- One sub-module, seg7_hex_decode: a combinational nibble -> 7-bit active-high decoder using the package table.
- Scan counters, snapshot logic, lz logic and output registers stay in dbg_7seg_scan.

Test Plan:
Common parameters: DIGITS=4, SCAN_DIV=8, GUARD=1, BRIGHT_W=2, both ACT_LOW=0.
- Reset and first frame: assert rst 3 cycles, then release with din=16'h1234, bright=3.
  - During reset: RAZR=0, SEG=0.
  - frame pulses at output cycle 1.
  - Digit 0 shows SEG=0x66 with RAZR=0001 for output cycles 2..8. Output cycle 1 and every cycle-1 thereafter are guard cycles with RAZR=0.
  - Digit 1 then shows 0x4F with RAZR=0010.
- Brightness: bright=0, so on_len=(1*7)>>2=1. Each digit is lit exactly 1 cycle (the cycle after guard) per 8-cycle dwell. bright=2 gives 5 cycles lit.
- Snapshot coherence: change din from 16'h1234 to 16'hABCD mid-frame. The current frame still shows 1,2,3,4; the next frame shows d (0x5E) on digit 0. With freeze=1 held across a frame start, 1234 persists.
- Leading zeros: din=16'h0030, lz_en=1 -> digits 3 and 2 never lit, digit 1 shows 0x4F, digit 0 shows 0x3F. din=16'h0000 -> only digit 0 lit, with 0x3F.
- Blank, dp and polarity: blank=4'b0100, dp=4'b0001, din=16'h8888 -> digit 2 is never lit, digit 0 shows SEG=0xFF. Rerun with SEG_ACT_LOW=1, RAZR_ACT_LOW=1 -> digit 0 shows SEG=0x00, RAZR=1110, and idle is all 1s.
- Reset mid-operation: assert rst at idx=2, cnt=5 -> the next output is all inactive. After release the scan restarts at digit 0 with a fresh capture, with frame asserted.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment debug display.
//   HEX_SEG       : hex nibble -> active-high gfedcba segment pattern
//   SEG_A..SEG_DP : bit positions of each segment on the SEG bus
//   on_len_width  : width that holds (bright+1)*(SCAN_DIV-GUARD) untruncated
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // (bright+1) needs bright_w+1 bits and (scan_div-guard) < scan_div needs
    // clog2(scan_div) bits, so the product fits in their sum.
    function automatic int on_len_width(input int scan_div, input int bright_w);
        return $clog2(scan_div) + bright_w + 1;
    endfunction

endpackage

// File: rtl/dbg_7seg_scan_if.sv
// dbg_7seg_scan_if: display-side bundle of the debug 7-segment scanner.
//   din/dp/blank : per-digit nibble, decimal point and forced blank
//   bright       : PWM brightness, 0 = dimmest
//   lz_en/freeze : leading-zero suppression enable, snapshot hold
//   RAZR/SEG     : digit selects and segment lines (polarity set by the driver)
//   frame        : one-cycle pulse at each frame start
//   master = source of display data, slave = the scanner.
interface dbg_7seg_scan_if #(
    parameter int DIGITS   = 8,
    parameter int BRIGHT_W = 4
);
    logic [4*DIGITS-1:0] din;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic [BRIGHT_W-1:0] bright;
    logic                lz_en;
    logic                freeze;
    logic [DIGITS-1:0]   RAZR;
    logic [7:0]          SEG;
    logic                frame;

    modport master (
        output din, dp, blank, bright, lz_en, freeze,
        input  RAZR, SEG, frame
    );

    modport slave (
        input  din, dp, blank, bright, lz_en, freeze,
        output RAZR, SEG, frame
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble -> 7-segment decoder.
//   nibble : 4-bit hex value
//   seg    : active-high segments, seg[0]=a .. seg[6]=g
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = HEX_SEG[nibble];
    end
endmodule

// File: rtl/dbg_7seg_scan.sv
// dbg_7seg_scan: multiplexed N-digit 7-segment debug display driver with
// frame-coherent snapshot, per-digit dp/blank, leading-zero suppression,
// PWM brightness, anti-ghosting guard time and configurable polarity.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : dbg_7seg_scan_if slave (display data in, RAZR/SEG/frame out)
module dbg_7seg_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 3125,
    parameter int GUARD        = 2,
    parameter int BRIGHT_W     = 4,
    parameter int SEG_ACT_LOW  = 1,
    parameter int RAZR_ACT_LOW = 1
) (
    input  logic           clk,
    input  logic           rst,
    dbg_7seg_scan_if.slave bus
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);
    localparam int ON_W  = on_len_width(SCAN_DIV, BRIGHT_W);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [ON_W-1:0]   GUARD_EXT = ON_W'(GUARD);
    localparam logic [ON_W-1:0]   SPAN      = ON_W'(SCAN_DIV - GUARD);
    localparam logic [DIGITS-1:0] RAZR_IDLE = (RAZR_ACT_LOW != 0) ? '1 : '0;
    localparam logic [7:0]        SEG_IDLE  = (SEG_ACT_LOW != 0) ? '1 : '0;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] snap_din;
    logic [DIGITS-1:0]   snap_dp;
    logic [DIGITS-1:0]   snap_blank;
    logic [DIGITS-1:0]   lz_mask;

    logic                frame_start;
    logic [ON_W-1:0]     product;
    logic [ON_W-1:0]     on_len;
    logic [ON_W-1:0]     cnt_ext;
    logic [3:0]          cur_nib;
    logic [6:0]          dec_seg;
    logic                lit;
    logic [DIGITS-1:0]   razr_hi;
    logic [7:0]          seg_hi;
    logic [DIGITS-1:0]   cap_mask;
    logic                zero_run;

    assign frame_start = (cnt == '0) && (idx == '0);

    assign product = (ON_W'(bus.bright) + ON_W'(1)) * SPAN;
    assign on_len  = product >> BRIGHT_W;
    assign cnt_ext = ON_W'(cnt);

    assign cur_nib = snap_din[{idx, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // Leading-zero mask from the value about to be captured: digit k is
    // suppressed when it and every more-significant nibble are zero.
    always_comb begin
        cap_mask = '0;
        zero_run = 1'b1;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run && (bus.din[4*k +: 4] == 4'h0);
            cap_mask[k] = zero_run;
        end
    end

    always_comb begin
        lit = (cnt_ext >= GUARD_EXT) && (cnt_ext < GUARD_EXT + on_len)
              && !snap_blank[idx] && !(bus.lz_en && lz_mask[idx]);
    end

    always_comb begin
        razr_hi = '0;
        seg_hi  = '0;
        if (lit) begin
            razr_hi[idx]         = 1'b1;
            seg_hi[SEG_G:SEG_A]  = dec_seg;
            seg_hi[SEG_DP]       = snap_dp[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            snap_din   <= '0;
            snap_dp    <= '0;
            snap_blank <= '0;
            lz_mask    <= '0;
            bus.RAZR   <= RAZR_IDLE;
            bus.SEG    <= SEG_IDLE;
            bus.frame  <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (frame_start && !bus.freeze) begin
                snap_din   <= bus.din;
                snap_dp    <= bus.dp;
                snap_blank <= bus.blank;
                lz_mask    <= cap_mask;
            end

            // XOR with the idle pattern inverts exactly when lines are active-low.
            bus.RAZR  <= razr_hi ^ RAZR_IDLE;
            bus.SEG   <= seg_hi ^ SEG_IDLE;
            bus.frame <= frame_start;
        end
    end
endmodule
